// File: rtl/multi_debounce_if.sv
// multi_debounce_if: bundles the per-channel button inputs and the debounced
// outputs of multi_debounce.
//   btn        : raw asynchronous button inputs (driven by master)
//   level      : registered debounced level per channel
//   rise, fall : one-cycle pulses on debounced 0->1 / 1->0 changes
//   long_press : one-cycle pulse after level has been held high long enough
// All outputs are plain registered levels/pulses; there is no handshake.
// A bit is meaningful on every cycle and carries no valid/ready.
interface multi_debounce_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] btn;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] long_press;

  modport master (
    output btn,
    input  level,
    input  rise,
    input  fall,
    input  long_press
  );

  modport slave (
    input  btn,
    output level,
    output rise,
    output fall,
    output long_press
  );
endinterface

// File: rtl/multi_debounce.sv
// multi_debounce: CHANNELS independent button debouncers with edge pulses and
// a long-press detector.
//   clk : single clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : multi_debounce_if.slave (btn in; level/rise/fall/long_press out)
// MODE 0 accepts a change immediately and then locks the channel out for
// LOCK_CYCLES cycles. MODE 1 accepts a change only after the synchronised
// input has differed from level for LOCK_CYCLES consecutive cycles.
module multi_debounce #(
  parameter int          CHANNELS    = 4,
  parameter int unsigned LOCK_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES = 50000000,
  parameter int          MODE        = 0
) (
  input logic             clk,
  input logic             rst,
  multi_debounce_if.slave bus
);

  // cnt never exceeds LOCK_CYCLES-1; hc saturates at LONG_CYCLES itself.
  localparam int CNT_W = $clog2(LOCK_CYCLES);
  localparam int HC_W  = $clog2(64'(LONG_CYCLES) + 64'd1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(LONG_CYCLES - 1);
  localparam logic [HC_W-1:0]  HC_MAX   = HC_W'(LONG_CYCLES);

  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] long_q, long_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [HC_W-1:0]     hc_q  [CHANNELS];
  logic [HC_W-1:0]     hc_d  [CHANNELS];

  always_comb begin
    sync1_d = bus.btn;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    long_d  = '0;
    cnt_d   = cnt_q;
    hc_d    = hc_q;

    for (int i = 0; i < CHANNELS; i++) begin
      if (MODE == 0) begin
        // Idle channel takes the new value at once; a running count is the
        // lockout window and ignores the input entirely.
        if (cnt_q[i] == '0) begin
          if (sync2_q[i] != level_q[i]) begin
            level_d[i] = sync2_q[i];
            cnt_d[i]   = CNT_W'(1);
          end
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        // Any cycle where the input agrees with level restarts the count,
        // so a glitch shorter than the interval never lands.
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end

      // Pulses are registered alongside level so they coincide with the
      // first cycle the new level is visible.
      rise_d[i] = level_d[i] & ~level_q[i];
      fall_d[i] = ~level_d[i] & level_q[i];

      if (!level_q[i]) begin
        hc_d[i] = '0;
      end else if (hc_q[i] != HC_MAX) begin
        hc_d[i] = hc_q[i] + HC_W'(1);
      end

      // hc passes through LONG_CYCLES-1 only once per press thanks to the
      // saturation above, so this fires at most once.
      long_d[i] = level_q[i] & (hc_q[i] == HC_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      long_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        hc_q[i]  <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        hc_q[i]  <= hc_d[i];
      end
    end
  end

  assign bus.level      = level_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.long_press = long_q;

endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce: drives one button vector into a MODE 0 and a MODE 1
// instance (CHANNELS=4, LOCK_CYCLES=8, LONG_CYCLES=20) and checks every
// output bit of both, cycle by cycle, against timings derived from the
// intended behaviour. Edge k counts from the first clock edge that samples
// a btn change (k=1).
module tb_multi_debounce;
  localparam int CH   = 4;
  localparam int LOCK = 8;
  localparam int LONG = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] btn;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4*CH-1:0] exp_q[$];
  logic [4*CH-1:0] e;
  logic [4*CH-1:0] g;

  always #5 clk = ~clk;

  multi_debounce_if #(.CHANNELS(CH)) bus0 ();
  multi_debounce_if #(.CHANNELS(CH)) bus1 ();
  assign bus0.btn = btn;
  assign bus1.btn = btn;

  multi_debounce #(.CHANNELS(CH), .LOCK_CYCLES(LOCK), .LONG_CYCLES(LONG), .MODE(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  multi_debounce #(.CHANNELS(CH), .LOCK_CYCLES(LOCK), .LONG_CYCLES(LONG), .MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------- clock / reset ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- packing helpers ----------------
  function automatic logic [4*CH-1:0] out0();
    return {bus0.level, bus0.rise, bus0.fall, bus0.long_press};
  endfunction

  function automatic logic [4*CH-1:0] out1();
    return {bus1.level, bus1.rise, bus1.fall, bus1.long_press};
  endfunction

  // Expected vector with the selected channels (mask m) at the given values
  // and every other channel at 0.
  function automatic logic [4*CH-1:0] chan(input logic [CH-1:0] m, input bit l,
                                           input bit r, input bit f, input bit p);
    logic [CH-1:0] z;
    z = '0;
    return {l ? m : z, r ? m : z, f ? m : z, p ? m : z};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    btn = '0;
    tick();
    tick();
    exp_q.push_back('0);
    exp_q.push_back('0);
    e = exp_q.pop_front(); g = out0(); n_cmp++;
    if (g !== e) begin n_bad++; $display("FAIL reset dut0: got %h expected %h", g, e); end
    e = exp_q.pop_front(); g = out1(); n_cmp++;
    if (g !== e) begin n_bad++; $display("FAIL reset dut1: got %h expected %h", g, e); end
    rst = 1'b0;
  endtask

  task automatic test_mode0_press();
    do_reset();
    btn = 4'b0001;
    for (int k = 1; k <= 14; k++) begin
      if (k == 6) btn[0] = 1'b0;  // release two edges after the rise
      exp_q.push_back(chan(4'b0001, k >= 3 && k < 11, k == 3, k == 11, 1'b0));
      tick();
      e = exp_q.pop_front(); g = out0(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL m0_press k=%0d: got %h expected %h", k, g, e); end
    end
  endtask

  task automatic test_mode1_glitch();
    do_reset();
    btn = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) btn = '0;  // only 5 cycles high
      exp_q.push_back('0);
      tick();
      e = exp_q.pop_front(); g = out1(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL m1_glitch k=%0d: got %h expected %h", k, g, e); end
    end
    btn = 4'b0010;
    for (int k = 1; k <= 14; k++) begin
      exp_q.push_back(chan(4'b0010, k >= 10, k == 10, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); g = out1(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL m1_hold k=%0d: got %h expected %h", k, g, e); end
    end
  endtask

  task automatic test_long_press();
    do_reset();
    btn = 4'b0100;
    for (int k = 1; k <= 40; k++) begin
      exp_q.push_back(chan(4'b0100, k >= 3, k == 3, 1'b0, k == 23));
      exp_q.push_back(chan(4'b0100, k >= 10, k == 10, 1'b0, k == 30));
      tick();
      e = exp_q.pop_front(); g = out0(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL long_a dut0 k=%0d: got %h expected %h", k, g, e); end
      e = exp_q.pop_front(); g = out1(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL long_a dut1 k=%0d: got %h expected %h", k, g, e); end
    end
    btn = '0;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back(chan(4'b0100, k < 3, 1'b0, k == 3, 1'b0));
      exp_q.push_back(chan(4'b0100, k < 10, 1'b0, k == 10, 1'b0));
      tick();
      e = exp_q.pop_front(); g = out0(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL long_rel dut0 k=%0d: got %h expected %h", k, g, e); end
      e = exp_q.pop_front(); g = out1(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL long_rel dut1 k=%0d: got %h expected %h", k, g, e); end
    end
    btn = 4'b0100;
    for (int k = 1; k <= 32; k++) begin
      exp_q.push_back(chan(4'b0100, k >= 3, k == 3, 1'b0, k == 23));
      exp_q.push_back(chan(4'b0100, k >= 10, k == 10, 1'b0, k == 30));
      tick();
      e = exp_q.pop_front(); g = out0(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL long_c dut0 k=%0d: got %h expected %h", k, g, e); end
      e = exp_q.pop_front(); g = out1(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL long_c dut1 k=%0d: got %h expected %h", k, g, e); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn = 4'b1000;
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(chan(4'b1000, k >= 3, k == 3, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); g = out0(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL rmid_pre k=%0d: got %h expected %h", k, g, e); end
    end
    rst = 1'b1;  // three cycles into the lockout window
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back('0);
      exp_q.push_back('0);
      tick();
      e = exp_q.pop_front(); g = out0(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL rmid_rst dut0 k=%0d: got %h expected %h", k, g, e); end
      e = exp_q.pop_front(); g = out1(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL rmid_rst dut1 k=%0d: got %h expected %h", k, g, e); end
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back(chan(4'b1000, k >= 3, k == 3, 1'b0, 1'b0));
      exp_q.push_back(chan(4'b1000, k >= 10, k == 10, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); g = out0(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL rmid_post dut0 k=%0d: got %h expected %h", k, g, e); end
      e = exp_q.pop_front(); g = out1(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL rmid_post dut1 k=%0d: got %h expected %h", k, g, e); end
    end
  endtask

  task automatic test_all_channels();
    do_reset();
    btn = 4'b1111;
    for (int k = 1; k <= 26; k++) begin
      if (k == 13) btn = '0;
      exp_q.push_back(chan(4'b1111, k >= 3 && k < 15, k == 3, k == 15, 1'b0));
      exp_q.push_back(chan(4'b1111, k >= 10 && k < 22, k == 10, k == 22, 1'b0));
      tick();
      e = exp_q.pop_front(); g = out0(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL all_ch dut0 k=%0d: got %h expected %h", k, g, e); end
      e = exp_q.pop_front(); g = out1(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL all_ch dut1 k=%0d: got %h expected %h", k, g, e); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    btn = '0;
    test_reset();
    test_mode0_press();
    test_mode1_glitch();
    test_long_press();
    test_reset_mid();
    test_all_channels();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent input channels, range 1..32.
REQ-002 SHALL have parameter LOCK_CYCLES, default 1000000: debounce interval in clk cycles, range 2..2^24.
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000: hold time in clk cycles for the long-press pulse, range 2..2^32-1.
REQ-004 SHALL have parameter MODE, default 0: 0 = accept-then-lockout, 1 = stable-for-interval.
REQ-005 SHALL derive all internal counter widths from the parameters via $clog2 and expose no width parameter.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port btn, input, CHANNELS bits: raw asynchronous button inputs.
REQ-009 SHALL have port level, output, CHANNELS bits: registered debounced level per channel.
REQ-010 SHALL have port rise, output, CHANNELS bits: one-cycle pulse on a debounced 0->1 change.
REQ-011 SHALL have port fall, output, CHANNELS bits: one-cycle pulse on a debounced 1->0 change.
REQ-012 SHALL have port long_press, output, CHANNELS bits: one-cycle pulse after level has been held at 1 for LONG_CYCLES cycles.

Function
REQ-013 SHALL pass each btn bit through a 2-flop synchronizer; the synchronizer output s[i] is the only source for the debounce logic.
REQ-014 SHALL process each channel independently, with no cross-channel interaction and no shared counters.
REQ-015 MODE 0: if cnt[i]==0 and s[i]!=level[i], SHALL set level[i]<=s[i] and cnt[i]<=1.
REQ-016 MODE 0: if cnt[i]!=0, SHALL increment cnt[i], and return it to 0 on the edge where cnt[i]==LOCK_CYCLES-1.
REQ-017 MODE 0: level[i] SHALL hold its value while cnt[i]!=0.
REQ-018 MODE 0: after a change at edge E, the earliest further change SHALL be at edge E+LOCK_CYCLES.
REQ-019 MODE 0: latency from btn change to level change with the channel idle SHALL be 3 edges, counting the first sampling edge as edge 1.
REQ-020 MODE 1: if s[i]==level[i], SHALL set cnt[i]<=0.
REQ-021 MODE 1: if s[i]!=level[i] and cnt[i]<LOCK_CYCLES-1, SHALL increment cnt[i].
REQ-022 MODE 1: if s[i]!=level[i] and cnt[i]==LOCK_CYCLES-1, SHALL set level[i]<=s[i] and cnt[i]<=0.
REQ-023 MODE 1: latency for a clean change SHALL be LOCK_CYCLES+2 edges.
REQ-024 MODE 1: any glitch shorter than LOCK_CYCLES cycles SHALL be rejected, with the counter restarting from 0.
REQ-025 rise[i] SHALL be registered and high for exactly the one cycle in which level[i] first reads 1; fall[i] SHALL behave likewise for the first cycle level[i] reads 0.
REQ-026 rise[i] and fall[i] SHALL never be high simultaneously.
REQ-027 SHALL keep a hold counter hc[i]: cleared when level[i]==0, incremented while level[i]==1, saturating at LONG_CYCLES.
REQ-028 long_press[i] SHALL be registered and high for one cycle on the edge where level[i]==1 and hc[i]==LONG_CYCLES-1, i.e. LONG_CYCLES edges after rise.
REQ-029 long_press[i] SHALL fire at most once per press; release clears hc[i] and the next press re-arms it.
REQ-030 If level[i] falls on the same edge hc[i] would reach LONG_CYCLES-1, long_press[i] SHALL NOT fire.
REQ-031 Counter arithmetic SHALL never wrap: cnt[i] is bounded by LOCK_CYCLES-1 and hc[i] saturates at LONG_CYCLES.

Reset
REQ-032 On rst==1 at a clk edge, SHALL clear the synchronizers and all of level, rise, fall, long_press, cnt and hc to 0.
REQ-033 Reset SHALL have priority over all other updates.
REQ-034 Reset asserted mid-lockout, mid-stability count or mid-hold SHALL abandon that operation with no pulse emitted.
REQ-035 After rst falls, a btn held at 1 SHALL be treated as a fresh 0->1 change per REQ-019/REQ-023.

Verification (CHANNELS=4, LOCK_CYCLES=8, LONG_CYCLES=20)
REQ-036 MODE 0, btn[0] 0->1 clean -> level[0]=1 and rise[0]=1 for one cycle after edge 3; other channels stay 0.
REQ-037 MODE 0, btn[0] 1->0 at edge 2 after the rise -> level[0] stays 1 through lockout, then falls at edge E+8 with fall[0] pulsing once.
REQ-038 MODE 1, btn[1] high for 5 cycles then low -> level[1], rise[1] stay 0; then btn[1] held high -> level[1]=1 after edge 10 counted from the first sampling edge.
REQ-039 btn[2] held high -> long_press[2] pulses once exactly 20 edges after rise[2]; holding longer produces no further pulse; release then repress produces a new pulse.
REQ-040 rst asserted 3 cycles into lockout, with btn[3] held high -> all outputs 0 during reset; level[3]=1 with rise[3] at edge 3 after rst falls.
REQ-041 btn=4'b1111 toggling simultaneously -> all four channels produce identical, independent, correctly timed level and pulse outputs.
